mat_weight_loader: RTL and testbench

//  Sequencer that loads a weight matrix from data memory into the MatUnit systolic array.
//  On start it reads num_rows row vectors from data memory at base_addr + r*stride.
//  It drives each row into the unit with set_weight/set_weight_row, then pulses done.

---
 rtl/mat_weight_loader.sv | 124 ++++++++++++
 tb/tb_mat_weight_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mat_weight_loader.sv
// Weight-matrix load sequencer: walks num_rows row vectors out of data memory
// at base + r*stride and writes each one into the MatUnit weight port, one cycle later.
module mat_weight_loader #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH),
  parameter int ELEM_W             = 32
) (
  input  logic                                 clock_i,
  input  logic                                 reset_i,
  input  logic                                 start_i,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]        base_addr_i,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]        stride_i,
  input  logic [WIDTH_ADDR_SIZE:0]             num_rows_i,
  input  logic                                 abort_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [DATA_MEM_ADDR_SIZE-1:0]        data_mem_read_addr_o,
  input  logic [WIDTH-1:0][ELEM_W-1:0]         data_mem_data_out_i,
  output logic                                 unit_set_weight_o,
  output logic [WIDTH_ADDR_SIZE-1:0]           unit_set_weight_row_o,
  output logic [WIDTH-1:0][ELEM_W-1:0]         unit_data_in_o
);

  // state  | meaning
  // IDLE   | waiting for start
  // LOAD   | presenting address of row r, capturing its data
  // DRAIN  | final row's write goes out
  // DONE   | one-cycle done pulse
  localparam int CW = WIDTH_ADDR_SIZE + 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);

  logic [1:0]                      state_q, state_d;
  logic [CW-1:0]                   n_q, n_d;
  logic [CW-1:0]                   r_q, r_d;
  logic [DATA_MEM_ADDR_SIZE-1:0]   stride_q, stride_d;
  logic [DATA_MEM_ADDR_SIZE-1:0]   addr_q, addr_d;
  logic                            wr_valid_q, wr_valid_d;
  logic [WIDTH_ADDR_SIZE-1:0]      wr_row_q, wr_row_d;
  logic [WIDTH-1:0][ELEM_W-1:0]    row_q, row_d;
  logic [CW-1:0]                   n_clamp;
  logic                            last_row;

  assign n_clamp  = (num_rows_i > WIDTH_C) ? WIDTH_C : num_rows_i;
  assign last_row = (r_q == (n_q - CW'(1)));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    r_d        = r_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    wr_valid_d = 1'b0;
    wr_row_d   = wr_row_q;
    row_d      = row_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          stride_d = stride_i;
          n_d      = n_clamp;
          r_d      = '0;
          if (n_clamp == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
            addr_d  = base_addr_i;
          end
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          row_d      = data_mem_data_out_i;
          wr_row_d   = r_q[WIDTH_ADDR_SIZE-1:0];
          wr_valid_d = 1'b1;
          r_d        = r_q + CW'(1);
          // the address register stops on the last row so it holds outside LOAD
          if (last_row) begin
            state_d = S_DRAIN;
          end else begin
            addr_d = addr_q + stride_q;
          end
        end
      end
      S_DRAIN: state_d = abort_i ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      r_q        <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_row_q   <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      r_q        <= r_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      wr_valid_q <= wr_valid_d;
      wr_row_q   <= wr_row_d;
      row_q      <= row_d;
    end
  end

  assign busy_o                = (state_q != S_IDLE);
  assign done_o                = (state_q == S_DONE);
  assign data_mem_read_addr_o  = addr_q;
  assign unit_set_weight_o     = wr_valid_q;
  assign unit_set_weight_row_o = wr_row_q;
  assign unit_data_in_o        = row_q;

endmodule

// File: tb/tb_mat_weight_loader.sv
// Directed bench for mat_weight_loader (WIDTH=4): table of load vectors plus
// hand-written abort and mid-load reset sequences.
module tb_mat_weight_loader;

  localparam int W  = 4;
  localparam int AW = 32;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [AW-1:0]        base;
  logic [AW-1:0]        stride;
  logic [2:0]           nrows;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic [AW-1:0]        raddr;
  logic [W-1:0][31:0]   dmem;
  logic                 sw;
  logic [1:0]           sw_row;
  logic [W-1:0][31:0]   udata;

  int n_chk  = 0;
  int n_fail = 0;

  mat_weight_loader #(.WIDTH(W), .DATA_MEM_ADDR_SIZE(AW)) dut (
    .clock_i              (clk),
    .reset_i              (rst),
    .start_i              (start),
    .base_addr_i          (base),
    .stride_i             (stride),
    .num_rows_i           (nrows),
    .abort_i              (abort),
    .busy_o               (busy),
    .done_o               (done),
    .data_mem_read_addr_o (raddr),
    .data_mem_data_out_i  (dmem),
    .unit_set_weight_o    (sw),
    .unit_set_weight_row_o(sw_row),
    .unit_data_in_o       (udata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data memory: each element encodes its address and lane index
  function automatic logic [W-1:0][31:0] mem_row(input logic [31:0] a);
    logic [W-1:0][31:0] r;
    for (int k = 0; k < W; k++) r[k] = {a[15:0], a[31:24], 8'(k)};
    return r;
  endfunction

  assign dmem = mem_row(raddr);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]      base;
    logic [31:0]      stride;
    logic [2:0]       nrows;
    int               exp_n;
    logic [3:0][31:0] exp_addr;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int n;
    n = v.exp_n;
    @(negedge clk);
    start = 1'b1; base = v.base; stride = v.stride; nrows = v.nrows;
    for (int k = 1; k <= n + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      chk($sformatf("v%0d k%0d done", id, k), 128'(done),
          128'((n == 0) ? (k == 1) : (k == n + 2)));
      chk($sformatf("v%0d k%0d busy", id, k), 128'(busy),
          128'((n == 0) ? (k == 1) : (k <= n + 2)));
      chk($sformatf("v%0d k%0d set_weight", id, k), 128'(sw),
          128'(k >= 2 && k <= n + 1));
      if (k >= 2 && k <= n + 1) begin
        chk($sformatf("v%0d k%0d row", id, k), 128'(sw_row), 128'(k - 2));
        chk($sformatf("v%0d k%0d data", id, k), 128'(udata), 128'(mem_row(v.exp_addr[k-2])));
      end
      if (k <= n)
        chk($sformatf("v%0d k%0d addr", id, k), 128'(raddr), 128'(v.exp_addr[k-1]));
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'd100, 32'd4, 3'd4, 4, {32'd112, 32'd108, 32'd104, 32'd100}};
    vecs[1] = '{32'd500, 32'd4, 3'd0, 0, {32'd0, 32'd0, 32'd0, 32'd0}};
    vecs[2] = '{32'd200, 32'd8, 3'd7, 4, {32'd224, 32'd216, 32'd208, 32'd200}};
    vecs[3] = '{32'hFFFF_FFFE, 32'd1, 3'd4, 4, {32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}};
    vecs[4] = '{32'h1000, 32'h10, 3'd2, 2, {32'd0, 32'd0, 32'h1010, 32'h1000}};
    vecs[5] = '{32'd50, 32'd3, 3'd1, 1, {32'd0, 32'd0, 32'd0, 32'd50}};

    rst = 1'b1; start = 1'b0; abort = 1'b0; base = '0; stride = '0; nrows = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset set_weight", 128'(sw), 128'(0));
    chk("reset row", 128'(sw_row), 128'(0));
    chk("reset addr", 128'(raddr), 128'(0));
    chk("reset data", 128'(udata), 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // abort while row 1 is being written; a mid-load start must be ignored
    @(negedge clk);
    start = 1'b1; base = 32'd300; stride = 32'd2; nrows = 3'd4;
    @(negedge clk); start = 1'b0;
    chk("abort k1 addr", 128'(raddr), 128'(32'd300));
    @(negedge clk);
    chk("abort k2 set_weight", 128'(sw), 128'(1));
    chk("abort k2 addr", 128'(raddr), 128'(32'd302));
    start = 1'b1; base = 32'd0; stride = 32'd0; nrows = 3'd1;
    @(negedge clk); start = 1'b0;
    chk("abort k3 set_weight", 128'(sw), 128'(1));
    chk("abort k3 row", 128'(sw_row), 128'(1));
    chk("abort k3 data", 128'(udata), 128'(mem_row(32'd302)));
    chk("abort k3 addr", 128'(raddr), 128'(32'd304));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort k4 busy", 128'(busy), 128'(0));
    chk("abort k4 addr", 128'(raddr), 128'(32'd304));
    for (int k = 4; k <= 7; k++) begin
      if (k > 4) @(negedge clk);
      chk($sformatf("abort k%0d set_weight", k), 128'(sw), 128'(0));
      chk($sformatf("abort k%0d done", k), 128'(done), 128'(0));
      chk($sformatf("abort k%0d busy", k), 128'(busy), 128'(0));
    end

    // reset in the middle of a load
    @(negedge clk);
    start = 1'b1; base = 32'd400; stride = 32'd1; nrows = 3'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midreset k3 addr", 128'(raddr), 128'(32'd402));
    chk("midreset k3 set_weight", 128'(sw), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("midreset busy", 128'(busy), 128'(0));
    chk("midreset done", 128'(done), 128'(0));
    chk("midreset set_weight", 128'(sw), 128'(0));
    chk("midreset row", 128'(sw_row), 128'(0));
    chk("midreset addr", 128'(raddr), 128'(0));
    chk("midreset data", 128'(udata), 128'(0));
    rst = 1'b0;
    run_vec('{32'd0, 32'd1, 3'd2, 2, {32'd0, 32'd0, 32'd1, 32'd0}}, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
